// File: rtl/mux_int_outq.sv
// Response queue behind the two-source integer mux: buffers valid mux words in a
// DEPTH-entry FIFO and hands them to a consumer over valid/ready, flagging lost words.
module mux_int_outq #(
    parameter int DW    = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] in_data,
    input  logic          in_resp,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow,
    input  logic          ovf_clr
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          drop;

    assign full      = (count == DEPTH_C);
    assign empty     = (count == '0);
    assign out_valid = !empty;

    assign pop  = out_valid & out_ready;
    assign push = in_resp & (!full | pop);
    assign drop = in_resp & full & !pop;

    // Head word is zeroed while empty so stale storage never leaks to the consumer.
    always_comb begin
        out_data = '0;
        if (!empty)
            out_data = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push && !reset)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule
